// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the seven-segment scan path.
package seg_pkg;
  localparam int          NUM_DIGITS  = 6;
  localparam int          DATA_W      = 24;
  localparam logic [23:0] MAX_DISPLAY = 24'd999999;
  localparam logic [5:0]  SEL_OFF     = 6'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } scan_state_e;
endpackage

// File: rtl/tick_counter.sv
// Terminal-count counter: tc is high in the last cycle of each LIMIT-cycle run.
module tick_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg_scan_sequencer.sv
// Rotating one-hot digit select with blank gaps; the display value only
// changes at frame boundaries so a whole frame shows one number.
module seg_scan_sequencer
  import seg_pkg::*;
#(
  parameter int          ON_CYCLES    = 50000,
  parameter int          BLANK_CYCLES = 500,
  parameter logic [23:0] MAX_VAL      = MAX_DISPLAY,
  parameter int          NUM_DIGITS   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] data_in,
  input  logic        data_in_vld,
  output logic [5:0]  sel,
  output logic [23:0] data_out,
  output logic        frame_start
);
  localparam int BLANK_LIMIT = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;

  scan_state_e state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic [5:0]  sel_d;
  logic        frame_d;
  logic        on_tc, blank_tc;
  logic [23:0] pend_q;
  logic        pend_flag;
  logic [23:0] data_sat;

  function automatic logic [23:0] sat_val(input logic [23:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  assign data_sat = sat_val(data_in);

  tick_counter #(.LIMIT(ON_CYCLES)) u_on_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!en),
    .en    (state_q == ON),
    .tc    (on_tc)
  );

  tick_counter #(.LIMIT(BLANK_LIMIT)) u_blank_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!en),
    .en    (state_q == BLANK),
    .tc    (blank_tc)
  );

  // next state, next digit and whether the coming cycle opens a frame
  always_comb begin
    logic advance;
    state_d = state_q;
    digit_d = digit_q;
    frame_d = 1'b0;
    advance = 1'b0;
    if (!en) begin
      state_d = IDLE;
      digit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ON;
          digit_d = '0;
          frame_d = 1'b1;
        end
        ON: begin
          if (on_tc) begin
            if (BLANK_CYCLES > 0) state_d = BLANK;
            else                  advance = 1'b1;
          end
        end
        BLANK: begin
          if (blank_tc) begin
            state_d = ON;
            advance = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          digit_d = '0;
        end
      endcase
    end
    if (advance) begin
      if (digit_q == 3'(NUM_DIGITS - 1)) begin
        digit_d = '0;
        frame_d = 1'b1;
      end else begin
        digit_d = digit_q + 3'd1;
      end
    end
    sel_d = (state_d == ON) ? (6'd1 << digit_d) : SEL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      digit_q     <= '0;
      sel         <= SEL_OFF;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      sel         <= sel_d;
      frame_start <= frame_d;
    end
  end

  // a strobe coincident with a frame load goes straight to data_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      pend_q    <= '0;
      pend_flag <= 1'b0;
    end else if (frame_d && (data_in_vld || pend_flag)) begin
      data_out  <= data_in_vld ? data_sat : pend_q;
      pend_flag <= 1'b0;
      if (data_in_vld) pend_q <= data_sat;
    end else if (data_in_vld) begin
      pend_q    <= data_sat;
      pend_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg_scan_sequencer.sv
// Bench for seg_scan_sequencer: a gapped build and a gapless build run side by side.
module tb_seg_scan_sequencer;
  localparam int ON = 4;
  localparam int BL [2] = '{1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] data_in = '0;
  logic        data_in_vld = 1'b0;
  logic [5:0]  sel_a, sel_b;
  logic [23:0] dout_a, dout_b;
  logic        fs_a, fs_b;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  seg_scan_sequencer #(.ON_CYCLES(ON), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .data_in_vld(data_in_vld),
    .sel(sel_a), .data_out(dout_a), .frame_start(fs_a)
  );

  seg_scan_sequencer #(.ON_CYCLES(ON), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .data_in_vld(data_in_vld),
    .sel(sel_b), .data_out(dout_b), .frame_start(fs_b)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: position p within a frame of 6*(ON+BLANK) cycles while running.
  bit          run [2];
  int          p [2];
  logic [23:0] m_pend [2];
  bit          m_flag [2];
  logic [23:0] m_dout [2];
  logic [5:0]  e_sel [2];
  bit          e_fs [2];

  function automatic logic [23:0] sat(input logic [23:0] v);
    return (v > 24'd999999) ? 24'd999999 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      int per;
      bit fs;
      per = ON + BL[k];
      if (!rst_n) begin
        run[k] = 0; p[k] = 0; m_pend[k] = '0; m_flag[k] = 0;
        m_dout[k] = '0; e_sel[k] = '0; e_fs[k] = 0;
      end else begin
        fs = 0;
        if (!en) begin
          run[k] = 0; p[k] = 0;
        end else if (!run[k]) begin
          run[k] = 1; p[k] = 0; fs = 1;
        end else begin
          p[k] = (p[k] + 1) % (6 * per);
          fs = (p[k] == 0);
        end
        if (fs && (data_in_vld || m_flag[k])) begin
          m_dout[k] = data_in_vld ? sat(data_in) : m_pend[k];
          if (data_in_vld) m_pend[k] = sat(data_in);
          m_flag[k] = 0;
        end else if (data_in_vld) begin
          m_pend[k] = sat(data_in);
          m_flag[k] = 1;
        end
        e_fs[k] = fs;
        e_sel[k] = (run[k] && (p[k] % per) < ON) ? 6'(1 << (p[k] / per)) : 6'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      chk("sel_gap", 32'(sel_a), 32'(e_sel[0]));
      chk("fs_gap", 32'(fs_a), 32'(e_fs[0]));
      chk("dout_gap", 32'(dout_a), 32'(m_dout[0]));
      chk("onehot_gap", 32'($onehot0(sel_a)), 32'd1);
      chk("sel_nogap", 32'(sel_b), 32'(e_sel[1]));
      chk("fs_nogap", 32'(fs_b), 32'(e_fs[1]));
      chk("dout_nogap", 32'(dout_b), 32'(m_dout[1]));
      chk("onehot_nogap", 32'($onehot0(sel_b)), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    step();
    while (!fs_a && n < 100) begin
      step();
      n++;
    end
    if (!fs_a) chk("wait_fs_timeout", 32'(fs_a), 32'd1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_sel", 32'(sel_a), 32'd0);
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_fs", 32'(fs_a), 32'd0);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    repeat (2) step();

    // rotation from enable
    en = 1'b1;
    step();
    chk("t1_sel0", 32'(sel_a), 32'd1);
    chk("t1_fs0", 32'(fs_a), 32'd1);
    repeat (4) step();
    chk("t1_blank", 32'(sel_a), 32'd0);
    chk("t1_nogap_d1", 32'(sel_b), 32'd2);
    step();
    chk("t1_sel1", 32'(sel_a), 32'd2);
    repeat (25) step();
    chk("t1_fs30", 32'(fs_a), 32'd1);
    chk("t1_sel30", 32'(sel_a), 32'd1);

    // mid-frame strobe shows up at next frame only
    repeat (3) step();
    data_in = 24'd123456; data_in_vld = 1'b1;
    step();
    data_in_vld = 1'b0;
    chk("t2_hold", 32'(dout_a), 32'd0);
    wait_fs();
    chk("t2_load", 32'(dout_a), 32'd123456);

    // saturation
    repeat (5) step();
    data_in = 24'd16777215; data_in_vld = 1'b1;
    step();
    data_in_vld = 1'b0;
    wait_fs();
    chk("t3_sat", 32'(dout_a), 32'd999999);

    // back-to-back strobes, then one coincident with the load cycle
    repeat (28) step();
    data_in = 24'd11; data_in_vld = 1'b1;
    step();
    data_in = 24'd22;
    step();
    chk("t4_fs", 32'(fs_a), 32'd1);
    chk("t4_22", 32'(dout_a), 32'd22);
    data_in = 24'd33;
    step();
    data_in_vld = 1'b0;
    chk("t4_still22", 32'(dout_a), 32'd22);
    wait_fs();
    chk("t4_33", 32'(dout_a), 32'd33);

    // disable at digit 3, then re-enable
    repeat (15) step();
    chk("t5_sel8", 32'(sel_a), 32'd8);
    en = 1'b0;
    step();
    chk("t5_off", 32'(sel_a), 32'd0);
    chk("t5_keep", 32'(dout_a), 32'd33);
    repeat (3) step();
    en = 1'b1;
    step();
    chk("t5_sel1", 32'(sel_a), 32'd1);
    chk("t5_fs", 32'(fs_a), 32'd1);

    // random enable/strobe run
    repeat (400) begin
      en = ($urandom_range(0, 19) != 0);
      data_in_vld = ($urandom_range(0, 7) == 0);
      data_in = 24'($urandom_range(0, 2000000));
      step();
    end
    en = 1'b1; data_in_vld = 1'b0;
    repeat (7) step();

    // asynchronous reset mid-frame
    rst_n = 1'b0;
    #1;
    chk("t6_arst_sel", 32'(sel_a), 32'd0);
    chk("t6_arst_dout", 32'(dout_a), 32'd0);
    chk("t6_arst_fs", 32'(fs_a), 32'd0);
    chk("t6_arst_sel_ng", 32'(sel_b), 32'd0);
    chk("t6_arst_dout_ng", 32'(dout_b), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
